// File: rtl/mips_bus_memory_responder_pkg.sv
// Shared types and helpers for the CPU memory-bus responder.
// Lane merge is the single place byte-enable semantics live.
package mips_bus_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef logic [3:0] byteen_t;

    typedef enum logic {IDLE, STALL} bus_resp_state_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input byteen_t     be);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/mips_bus_memory_responder_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that steps once per accepted transfer.
module bus_stall_lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= 8'hA5;
        else if (advance)
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign value = r_lfsr;
endmodule

// File: rtl/mips_bus_memory_responder.sv
// Word RAM behind the CPU bus with byte-lane writes, fixed or pseudo-random
// waitrequest stalls, and a registered pulse on any protocol violation.
module mips_bus_memory_responder
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 0,
    parameter int          RANDOM_WAIT = 0,
    localparam int         IW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   address,
    input  logic          write,
    input  logic          read,
    output logic          waitrequest,
    input  logic [31:0]   writedata,
    input  byteen_t       byteenable,
    output logic [31:0]   readdata,
    input  logic          init_we,
    input  logic [IW-1:0] init_index,
    input  logic [31:0]   init_data,
    output logic          protocol_err
);
    logic [31:0]     r_ram [DEPTH];
    bus_resp_state_t r_state, w_state_nx;
    logic [7:0]      r_cnt, w_cnt_nx, w_stalls;
    logic [31:0]     r_addr, r_rdata;
    logic            r_rd, r_wr, r_perr;
    logic            w_req, w_acc, w_abort, w_err, w_in_range;
    logic [31:0]     w_off;
    logic [IW-1:0]   w_idx;

    assign w_req      = read | write;
    assign w_off      = address - BASE_ADDR;
    assign w_idx      = w_off[IW+1:2];
    assign w_in_range = (address >= BASE_ADDR) && (w_off[31:2] < 30'(DEPTH)) &&
                        (w_off[1:0] == 2'b00);

    generate
        if (RANDOM_WAIT != 0) begin : g_rand
            logic [7:0] w_lfsr;
            bus_stall_lfsr8 u_lfsr (
                .clk     (clk),
                .reset   (reset),
                .advance (w_acc),
                .value   (w_lfsr)
            );
            assign w_stalls = 8'({1'b0, w_lfsr} % 9'(WAIT_CYCLES + 1));
        end else begin : g_fixed
            assign w_stalls = 8'(WAIT_CYCLES);
        end
    endgenerate

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        waitrequest = 1'b0;
        w_acc       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: if (w_req) begin
                if (w_stalls == 8'd0) begin
                    w_acc = 1'b1;
                end else begin
                    waitrequest = 1'b1;
                    w_cnt_nx    = w_stalls;
                    w_state_nx  = STALL;
                end
            end
            STALL: begin
                // A master that changes or drops its request mid-stall gets nothing committed.
                if (!w_req || address != r_addr || read != r_rd || write != r_wr) begin
                    w_abort     = 1'b1;
                    waitrequest = w_req;
                    w_cnt_nx    = 8'd0;
                    w_state_nx  = IDLE;
                end else if (r_cnt > 8'd1) begin
                    waitrequest = 1'b1;
                    w_cnt_nx    = r_cnt - 8'd1;
                end else begin
                    w_acc      = 1'b1;
                    w_cnt_nx   = 8'd0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Address 0 reads are the CPU's idle fetch and are quietly answered with zero.
    assign w_err = w_abort | (w_acc & ((read & write) | (write & !w_in_range) |
                   (read & !write & !w_in_range & (address != 32'h0))));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= 32'h0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'h0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_perr  <= w_err;
            if (r_state == IDLE && w_req) begin
                r_addr <= address;
                r_rd   <= read;
                r_wr   <= write;
            end
            if (w_acc && read && !write)
                r_rdata <= w_in_range ? r_ram[w_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (init_we)
            r_ram[init_index] <= init_data;
        else if (!reset && w_acc && write && w_in_range)
            r_ram[w_idx] <= lane_merge(r_ram[w_idx], writedata, byteenable);
    end

    assign readdata     = r_rdata;
    assign protocol_err = r_perr;
endmodule

// File: tb/tb_mips_bus_memory_responder.sv
// Directed bench: four responders (wait 0, 3, 2, random<=7) on separate buses, shared backdoor.
module tb_mips_bus_memory_responder;
    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr [NI];
    logic [31:0] wdata [NI];
    logic [31:0] rdata [NI];
    logic        rd [NI];
    logic        wr [NI];
    logic        wreq [NI];
    logic        perr [NI];
    logic [3:0]  be [NI];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mips_bus_memory_responder #(
                .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 7),
                .RANDOM_WAIT ((g == 3) ? 1 : 0)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .address      (addr[g]),
                .write        (wr[g]),
                .read         (rd[g]),
                .waitrequest  (wreq[g]),
                .writedata    (wdata[g]),
                .byteenable   (be[g]),
                .readdata     (rdata[g]),
                .init_we      (init_we),
                .init_index   (init_idx),
                .init_data    (init_data),
                .protocol_err (perr[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int i, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_idx = 6'(i); init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Holds the request until accepted; returns just after the accept edge.
    task automatic xfer(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, output int st);
        int n;
        n = 0;
        @(negedge clk);
        addr[k] = a; rd[k] = r; wr[k] = w; wdata[k] = d; be[k] = b;
        #1;
        while (wreq[k] === 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        st = n;
        @(posedge clk);
        #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    initial begin
        int st, maxst, idx;
        logic [31:0] model [16];
        logic [31:0] d;
        logic [3:0] b;

        for (int k = 0; k < NI; k++) begin
            addr[k] = 32'h0; wdata[k] = 32'h0; rd[k] = 1'b0; wr[k] = 1'b0; be[k] = 4'h0;
        end
        init_we = 1'b0; init_idx = 6'd0; init_data = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_readdata", rdata[k], 32'h0);
            chk("rst_perr", 32'(perr[k]), 32'h0);
            chk("rst_wreq", 32'(wreq[k]), 32'h0);
        end

        // Zero-wait read of preloaded word
        preload(1, 32'h8D09002C);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, st);
        chk("t1_stalls", 32'(st), 32'd0);
        chk("t1_rdata", rdata[0], 32'h8D09002C);
        chk("t1_perr", 32'(perr[0]), 32'h0);

        // Three-stall write then read back
        xfer(1, 1'b0, 1'b1, 32'hBFC00030, 32'hDEADBEEF, 4'hF, st);
        chk("t2_wr_stalls", 32'(st), 32'd3);
        xfer(1, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, st);
        chk("t2_rd_stalls", 32'(st), 32'd3);
        chk("t2_rdata", rdata[1], 32'hDEADBEEF);

        // Byte lanes
        preload(12, 32'h11223344);
        xfer(0, 1'b0, 1'b1, 32'hBFC00030, 32'hAABBCCDD, 4'b0101, st);
        xfer(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, st);
        chk("t3_be0101", rdata[0], 32'h11BB33DD);
        xfer(0, 1'b0, 1'b1, 32'hBFC00030, 32'hFFFFFFFF, 4'b0000, st);
        xfer(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, st);
        chk("t3_be0000", rdata[0], 32'h11BB33DD);

        // Out of range, misaligned, idle fetch, read+write collision
        xfer(0, 1'b1, 1'b0, 32'hBFC00400, 32'h0, 4'h0, st);
        chk("t4_oor_rdata", rdata[0], 32'h0);
        chk("t4_oor_perr", 32'(perr[0]), 32'h1);
        @(posedge clk); #1;
        chk("t4_perr_pulse", 32'(perr[0]), 32'h0);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, st);
        chk("t4_reread", rdata[0], 32'h8D09002C);
        xfer(0, 1'b1, 1'b0, 32'hBFC00002, 32'h0, 4'h0, st);
        chk("t4_misal_rdata", rdata[0], 32'h0);
        chk("t4_misal_perr", 32'(perr[0]), 32'h1);
        xfer(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'h0, st);
        chk("t4_below_perr", 32'(perr[0]), 32'h1);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, st);
        xfer(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0, st);
        chk("t4_zero_rdata", rdata[0], 32'h0);
        chk("t4_zero_perr", 32'(perr[0]), 32'h0);
        xfer(0, 1'b1, 1'b1, 32'hBFC00008, 32'h12345678, 4'hF, st);
        chk("t4_rw_perr", 32'(perr[0]), 32'h1);
        xfer(0, 1'b1, 1'b0, 32'hBFC00008, 32'h0, 4'h0, st);
        chk("t4_rw_data", rdata[0], 32'h12345678);
        chk("t4_rw_noerr", 32'(perr[0]), 32'h0);
        xfer(0, 1'b0, 1'b1, 32'hBFC00400, 32'h1, 4'hF, st);
        chk("t4_oor_wr_perr", 32'(perr[0]), 32'h1);

        // Dropped request mid-stall
        @(negedge clk);
        addr[2] = 32'hBFC00004; rd[2] = 1'b1; wr[2] = 1'b0;
        #1 chk("t5_first_wreq", 32'(wreq[2]), 32'h1);
        @(negedge clk);
        rd[2] = 1'b0;
        @(posedge clk); #1;
        chk("t5_abort_perr", 32'(perr[2]), 32'h1);
        chk("t5_abort_rdata", rdata[2], 32'h0);
        xfer(2, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, st);
        chk("t5_stalls", 32'(st), 32'd2);
        chk("t5_rdata", rdata[2], 32'h8D09002C);
        chk("t5_perr", 32'(perr[2]), 32'h0);

        // Reset during a stalled write commits nothing
        preload(16, 32'h0);
        @(negedge clk);
        addr[1] = 32'hBFC00040; wr[1] = 1'b1; rd[1] = 1'b0; wdata[1] = 32'h55; be[1] = 4'hF;
        @(negedge clk);
        #1 chk("rst_stall_wreq", 32'(wreq[1]), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr[1] = 1'b0;
        #1 chk("rst_stall_idle", 32'(wreq[1]), 32'h0);
        xfer(1, 1'b1, 1'b0, 32'hBFC00040, 32'h0, 4'h0, st);
        chk("rst_stall_nocommit", rdata[1], 32'h0);
        chk("rst_stall_count", 32'(st), 32'd3);

        // Random stalls against a scoreboard
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            preload(i, model[i]);
        end
        maxst = 0;
        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(15);
            if ($urandom_range(1) == 1) begin
                d = $urandom;
                b = 4'($urandom_range(15));
                xfer(3, 1'b0, 1'b1, 32'hBFC00000 + 32'(idx * 4), d, b, st);
                for (int l = 0; l < 4; l++)
                    if (b[l]) model[idx][8*l +: 8] = d[8*l +: 8];
            end else begin
                xfer(3, 1'b1, 1'b0, 32'hBFC00000 + 32'(idx * 4), 32'h0, 4'h0, st);
                chk("t6_rdata", rdata[3], model[idx]);
            end
            chk("t6_stall_range", 32'(st <= 7), 32'd1);
            chk("t6_perr", 32'(perr[3]), 32'h0);
            if (st > maxst) maxst = st;
        end
        chk("t6_some_stall", 32'(maxst > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
